// File: rtl/fpu_arbiter.sv
// Two-requester round-robin front end for a single shared FPU.
// One operation in flight; a timed-out operation returns a quiet NaN with resp_err set.
module fpu_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_rdy,
    output logic [1:0]  req_ack,
    input  logic [7:0]  req_command,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    output logic [1:0]  resp_rdy,
    input  logic [1:0]  resp_ack,
    output logic [31:0] resp_result,
    output logic        resp_err,
    output logic [3:0]  fpu_command,
    output logic [31:0] fpu_data_a,
    output logic [31:0] fpu_data_b,
    output logic        fpu_input_rdy,
    output logic        fpu_output_ack,
    input  logic        fpu_input_ack,
    input  logic        fpu_output_rdy,
    input  logic [31:0] fpu_result
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    localparam logic [7:0]  CNT_MAX = 8'(TIMEOUT - 1);
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;

    state_t      state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        grant, grant_nxt;
    logic        pick;
    logic [1:0]  grant_oh;
    logic        timed_out;
    logic [1:0]  req_ack_nxt, resp_rdy_nxt;
    logic [31:0] result_nxt;
    logic        err_nxt, in_rdy_nxt, out_ack_nxt;
    logic [3:0]  cmd_nxt;
    logic [31:0] a_nxt, b_nxt;

    // grant holds the last winner; on contention the other requester wins
    assign pick      = (&req_rdy) ? ~grant : req_rdy[1];
    assign grant_oh  = grant ? 2'b10 : 2'b01;
    assign timed_out = (cnt == CNT_MAX);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            grant          <= 1'b1;
            req_ack        <= '0;
            resp_rdy       <= '0;
            resp_result    <= '0;
            resp_err       <= 1'b0;
            fpu_input_rdy  <= 1'b0;
            fpu_output_ack <= 1'b0;
            fpu_command    <= '0;
            fpu_data_a     <= '0;
            fpu_data_b     <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            grant          <= grant_nxt;
            req_ack        <= req_ack_nxt;
            resp_rdy       <= resp_rdy_nxt;
            resp_result    <= result_nxt;
            resp_err       <= err_nxt;
            fpu_input_rdy  <= in_rdy_nxt;
            fpu_output_ack <= out_ack_nxt;
            fpu_command    <= cmd_nxt;
            fpu_data_a     <= a_nxt;
            fpu_data_b     <= b_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        grant_nxt    = grant;
        req_ack_nxt  = 2'b00;
        resp_rdy_nxt = resp_rdy;
        result_nxt   = resp_result;
        err_nxt      = resp_err;
        in_rdy_nxt   = fpu_input_rdy;
        out_ack_nxt  = 1'b0;
        cmd_nxt      = fpu_command;
        a_nxt        = fpu_data_a;
        b_nxt        = fpu_data_b;

        unique case (state)
            IDLE: begin
                if (|req_rdy) begin
                    grant_nxt   = pick;
                    req_ack_nxt = pick ? 2'b10 : 2'b01;
                    cmd_nxt     = pick ? req_command[7:4] : req_command[3:0];
                    a_nxt       = pick ? req_a[63:32] : req_a[31:0];
                    b_nxt       = pick ? req_b[63:32] : req_b[31:0];
                    in_rdy_nxt  = 1'b1;
                    cnt_nxt     = '0;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_nxt = cnt + 8'd1;
                if (timed_out) begin
                    result_nxt   = QNAN;
                    err_nxt      = 1'b1;
                    in_rdy_nxt   = 1'b0;
                    resp_rdy_nxt = grant_oh;
                    state_nxt    = RESPOND;
                end else if (fpu_input_ack) begin
                    in_rdy_nxt = 1'b0;
                    state_nxt  = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt + 8'd1;
                // a result arriving on the last allowed cycle still counts
                if (fpu_output_rdy) begin
                    result_nxt   = fpu_result;
                    err_nxt      = 1'b0;
                    out_ack_nxt  = 1'b1;
                    resp_rdy_nxt = grant_oh;
                    state_nxt    = RESPOND;
                end else if (timed_out) begin
                    result_nxt   = QNAN;
                    err_nxt      = 1'b1;
                    in_rdy_nxt   = 1'b0;
                    resp_rdy_nxt = grant_oh;
                    state_nxt    = RESPOND;
                end
            end
            RESPOND: begin
                if (resp_ack[grant]) begin
                    resp_rdy_nxt = 2'b00;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
